// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// Module : rf_wb_arbiter_if
// Brief  : Writeback requester bus and register-file write port bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      hold;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [ID_W-1:0]           grant_id;
  logic                      conflict;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, grant_id, conflict
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, grant_id, conflict
  );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module : rf_wb_arbiter
// Brief  : Round-robin arbiter for the register file's single write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int              ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_found;
  logic               many;
  logic [NUM_REQ-1:0] nz;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] zero_ack;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [ADDR_W-1:0]  addr_a [NUM_REQ];
  logic [DATA_W-1:0]  data_a [NUM_REQ];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
      assign data_a[i] = bus.req_data[i*DATA_W +: DATA_W];
      assign nz[i]     = |addr_a[i];
    end
  endgenerate

  // Reset also blocks grants so nothing is acknowledged that cannot be written.
  assign elig     = bus.req_valid & nz & {NUM_REQ{~(bus.hold | rst)}};
  assign zero_ack = bus.req_valid & ~nz;

  always_comb begin : find_winner
    int              idx;
    logic [ID_W-1:0] idx_v;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = ID_W'(idx);
      if (!gnt_found && elig[idx_v]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_v;
      end
    end
  end

  always_comb begin : count_eligible
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) cnt = cnt + int'(elig[i]);
    many = (cnt > 1);
  end

  always_comb begin
    gnt_onehot = '0;
    if (gnt_found) gnt_onehot[gnt_idx] = 1'b1;
  end

  assign ptr_nxt       = (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
  assign bus.req_ready = zero_ack | gnt_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.grant_id <= '0;
      bus.conflict <= 1'b0;
    end else begin
      bus.wr_en    <= gnt_found;
      bus.conflict <= many;
      if (gnt_found) begin
        ptr          <= ptr_nxt;
        bus.wr_addr  <= addr_a[gnt_idx];
        bus.wr_data  <= data_a[gnt_idx];
        bus.grant_id <= gnt_idx;
      end
    end
  end
endmodule

`default_nettype wire
